// File: rtl/ft232r_host.sv
// ft232r_host: FT232R-style 8N1 UART host with receive FIFO.
// Define FT232R_HOST_FLOW_EN to enable RTS/CTS flow control.
module ft232r_host #(
  parameter int BIT_CLKS   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       txd,
  input  logic       rxd,
  output logic       rts_n,
  input  logic       cts_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       rx_req,
  output logic [7:0] rx_data,
  input  logic       rx_ack,
  output logic       rx_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] BIT_END  = 8'(BIT_CLKS - 1);
  localparam logic [7:0] HALF_END = 8'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);

  logic [1:0] rxd_sync;
  logic       rxd_s;
  logic       rxd_prev;
  logic       cts_ok;

  assign rxd_s = rxd_sync[1];

  // Synchronize rxd and keep one delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_sync <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd};
      rxd_prev <= rxd_s;
    end
  end

`ifdef FT232R_HOST_FLOW_EN
  logic [1:0] cts_sync;

  // Synchronize the far-end clear-to-send
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_sync <= 2'b11;
    else        cts_sync <= {cts_sync[0], cts_n};
  end

  assign cts_ok = ~cts_sync[1];
`else
  logic unused_cts;
  assign unused_cts = cts_n;
  assign cts_ok     = 1'b1;
`endif

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT_CTS,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t  tx_state;
  logic [7:0] tx_sh;
  logic [7:0] tx_cnt;
  logic [2:0] tx_bit;
  logic       tx_end;

  assign tx_end = (tx_cnt == BIT_END);

  // Transmit FSM: handshake, wait for CTS, then a fixed-length frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_sh    <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
      tx_ack   <= 1'b0;
    end else begin
      tx_ack <= 1'b0;
      unique case (tx_state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (tx_req) begin
            tx_sh    <= tx_data;
            tx_ack   <= 1'b1;
            tx_state <= TX_WAIT_CTS;
          end
        end
        TX_WAIT_CTS: begin
          if (cts_ok) begin
            txd      <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_end) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 8'd1;
          end
        end
        TX_DATA: begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 8'd1;
          end
        end
        TX_STOP: begin
          if (tx_end) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 8'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t  rx_state;
  logic [7:0] rx_sh;
  logic [7:0] rx_cnt;
  logic [2:0] rx_bit;
  logic       rx_end;
  logic       stop_hit;
  logic       push;
  logic       frame_err;

  assign rx_end    = (rx_cnt == BIT_END);
  assign stop_hit  = (rx_state == RX_STOP) && rx_end;
  assign push      = stop_hit && rxd_s;
  assign frame_err = stop_hit && !rxd_s;

  // Receive FSM: mid-bit sampling, glitch reject on the start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_sh    <= '0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 8'd1;
          end
        end
        RX_DATA: begin
          if (rx_end) begin
            rx_cnt <= '0;
            rx_sh  <= {rxd_s, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 8'd1;
          end
        end
        RX_STOP: begin
          if (rx_end) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 8'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          pop;
  logic          full;
  logic          wr_ok;
  logic          overflow;

  assign pop      = rx_ack && (count != '0);
  assign full     = (count == FULL_LVL);
  assign wr_ok    = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign rx_req   = (count != '0);
  assign rx_data  = mem[rd_ptr];

  // Next occupancy; a push and pop in the same cycle cancel
  always_comb begin
    count_next = count;
    if (wr_ok && !pop)      count_next = count + CW'(1);
    else if (!wr_ok && pop) count_next = count - CW'(1);
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= rx_sh;
  end

  // FIFO pointers, occupancy and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rx_err <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count  <= count_next;
      rx_err <= frame_err || overflow;
    end
  end

`ifdef FT232R_HOST_FLOW_EN
  localparam logic [CW-1:0] RTS_LVL = CW'(FIFO_DEPTH - 1);

  // Deassert ready one entry before full to leave room in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rts_n <= 1'b1;
    else        rts_n <= (count_next >= RTS_LVL);
  end
`else
  assign rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_ft232r_host.sv
// tb_ft232r_host: self-checking bench for ft232r_host.
// Honours FT232R_HOST_FLOW_EN to select flow-control expectations.
module tb_ft232r_host;

  localparam int B = 10;
  localparam int D = 4;
`ifdef FT232R_HOST_FLOW_EN
  localparam logic FLOW = 1'b1;
`else
  localparam logic FLOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txd;
  logic       rxd;
  logic       rts_n;
  logic       cts_n = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ack;
  logic       rx_req;
  logic [7:0] rx_data;
  logic       rx_ack = 1'b0;
  logic       rx_err;

  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int ack_seen = 0;
  int e0, a0, mism, lat, r;
  bit ok, ok2, st, xp;
  logic [7:0] b, cb, v;
  logic [7:0] q[$];

  typedef struct {
    bit         glitch;
    logic [7:0] data;
    bit         stop;
    bit         exp_push;
    bit         exp_err;
  } vec_t;
  vec_t vt[6];

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  ft232r_host #(.BIT_CLKS(B), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .txd(txd), .rxd(rxd),
    .rts_n(rts_n), .cts_n(cts_n), .tx_req(tx_req),
    .tx_data(tx_data), .tx_ack(tx_ack), .rx_req(rx_req),
    .rx_data(rx_data), .rx_ack(rx_ack), .rx_err(rx_err)
  );

  always @(negedge clk) begin
    if (rx_err) err_seen++;
    if (tx_ack) ack_seen++;
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_send(input logic [7:0] d, output bit got);
    got = 1'b0;
    tx_data = d;
    tx_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    tx_req = 1'b0;
  endtask

  task automatic wait_start(int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic tx_capture(output logic [7:0] d, output bit got);
    d = 8'h00;
    wait_start(20, got);
    if (got) begin
      repeat (B / 2 + B) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        d[k] = txd;
        repeat (B) @(negedge clk);
      end
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input bit stp);
    rxd_drv = 1'b0;
    cyc(B);
    for (int k = 0; k < 8; k++) begin
      rxd_drv = d[k];
      cyc(B);
    end
    rxd_drv = stp;
    cyc(B);
    rxd_drv = 1'b1;
    cyc(B);
  endtask

  task automatic drive_glitch();
    rxd_drv = 1'b0;
    cyc(2);
    rxd_drv = 1'b1;
    cyc(3 * B);
  endtask

  task automatic pop_check(string nm, logic [7:0] exp);
    check({nm, "_req"}, rx_req, 1);
    check({nm, "_data"}, rx_data, exp);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 8'h5C, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 8'h5C, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b0, 8'h81, 1'b0, 1'b0, 1'b1};

    // reset state
    cyc(3);
    check("rst_txd", txd, 1);
    check("rst_rts_n", rts_n, FLOW);
    check("rst_tx_ack", tx_ack, 0);
    check("rst_rx_req", rx_req, 0);
    check("rst_rx_err", rx_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_rts_n", rts_n, 0);
    @(negedge clk);

    // loopback 0xAE, cts toggled mid-frame
    loop_en = 1'b1;
    a0 = ack_seen;
    e0 = err_seen;
    v = 8'hAE;
    tx_send(v, ok);
    check("ae_ack", ok, 1);
    wait_start(20, ok);
    check("ae_start", ok, 1);
    mism = 0;
    for (int i = 0; i <= 10 * B; i++) begin
      if (i < B) xp = 1'b0;
      else if (i < 9 * B) xp = v[i / B - 1];
      else xp = 1'b1;
      if (txd !== xp) mism++;
      if (i == 30) cts_n = 1'b1;
      @(negedge clk);
    end
    cts_n = 1'b0;
    check("ae_wave_mism", mism, 0);
    cyc(10);
    check("ae_ack_cnt", ack_seen - a0, 1);
    check("ae_err", err_seen - e0, 0);
    pop_check("ae_rx", 8'hAE);
    check("ae_empty", rx_req, 0);

    // cts hold-off
    cts_n = 1'b1;
    cyc(4);
    tx_send(8'hB1, ok);
    check("b1_ack", ok, 1);
`ifdef FT232R_HOST_FLOW_EN
    mism = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1) mism++;
      @(negedge clk);
    end
    check("b1_hold", mism, 0);
    cts_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        lat = i;
        break;
      end
    end
    check("b1_cts_lat", (lat >= 1 && lat <= 3), 1);
`else
    wait_start(6, ok);
    check("b1_no_cts_wait", ok, 1);
`endif
    cts_n = 1'b0;
    cyc(10 * B + 10);
    pop_check("b1_rx", 8'hB1);

    // fill FIFO by loopback, then overflow
    e0 = err_seen;
    for (int k = 1; k <= 5; k++) begin
      tx_send(8'(k), ok);
      wait_start(20, ok2);
      check("ovf_tx", {ok, ok2}, 2'b11);
      cyc(10 * B + 10);
      if (k <= 4) check("ovf_rts", rts_n, FLOW && k >= 3);
    end
    check("ovf_err", err_seen - e0, 1);
    for (int k = 1; k <= 4; k++) pop_check("ovf_pop", 8'(k));
    check("ovf_empty", rx_req, 0);
    @(negedge clk);
    check("ovf_rts_low", rts_n, 0);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("empty_ack", rx_req, 0);

    // table-driven rx frames
    loop_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e0 = err_seen;
      if (vt[i].glitch) drive_glitch();
      else drive_rx(vt[i].data, vt[i].stop);
      check("vec_err", err_seen - e0, vt[i].exp_err);
      check("vec_req", rx_req, vt[i].exp_push);
      if (vt[i].exp_push) pop_check("vec_pop", vt[i].data);
    end

    // random rx/tx traffic against a queue model
    q.delete();
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 5);
      if (r <= 3) begin
        b = 8'($urandom);
        st = (r != 3);
        e0 = err_seen;
        if (r == 0) begin
          v = 8'($urandom);
          fork
            drive_rx(b, st);
            begin
              tx_send(v, ok);
              tx_capture(cb, ok2);
            end
          join
          check("rnd_tx", {ok, ok2, cb}, {2'b11, v});
        end else begin
          drive_rx(b, st);
        end
        xp = !st || (q.size() == D);
        if (st && q.size() < D) q.push_back(b);
        check("rnd_err", err_seen - e0, xp);
      end else begin
        if (q.size() != 0) begin
          check("rnd_pop_data", rx_data, q[0]);
          void'(q.pop_front());
        end
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
      end
      check("rnd_req", rx_req, q.size() != 0);
      check("rnd_rts", rts_n, FLOW && q.size() >= D - 1);
      if (q.size() != 0) check("rnd_head", rx_data, q[0]);
    end
    while (q.size() != 0) pop_check("rnd_drain", q.pop_front());
    check("rnd_drained", rx_req, 0);

    // reset in the middle of data bit 4
    loop_en = 1'b1;
    e0 = err_seen;
    tx_send(8'h5C, ok);
    wait_start(20, ok2);
    check("rst_mid_tx", {ok, ok2}, 2'b11);
    cyc(5 * B + B / 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txd", txd, 1);
    check("rst_mid_rts", rts_n, FLOW);
    cyc(3);
    rst_n = 1'b1;
    cyc(15 * B);
    check("rst_mid_req", rx_req, 0);
    check("rst_mid_err", err_seen - e0, 0);
    check("rst_mid_idle", txd, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
